// File: rtl/fft_input_buffer.sv
// fft_input_buffer: ping-pong sample buffer feeding the 8-point FFT datapath.
//
// Accepts one WIDTH-bit real sample per clock on a valid/ready stream, assembles
// groups of 8 samples into a frame (optionally in bit-reversed slot order) and
// presents the complete frame in parallel on a second valid/ready handshake.
//
// Ports:
//   clk         - system clock, all state updates on the rising edge
//   rst         - synchronous, active-high reset
//   in_data     - incoming sample
//   in_valid    - in_data is valid this cycle
//   in_ready    - buffer can accept a sample this cycle
//   frame_data  - assembled frame, slot s at bits [s*WIDTH +: WIDTH]
//   frame_valid - frame_data holds a complete frame
//   frame_ready - downstream consumes the frame this cycle
module fft_input_buffer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned BITREV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [8*WIDTH-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready
);

  // Two banks of 8 sample registers, one full flag per bank.
  logic [WIDTH-1:0] bank_q [2][8];
  logic [WIDTH-1:0] bank_d [2][8];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [2:0]       wr_cnt_q, wr_cnt_d;
  logic             rd_bank_q, rd_bank_d;

  logic             accept;
  logic             frame_rel;
  logic [2:0]       wr_slot;

  // Handshake decode. in_ready depends only on registered state and rst, so
  // there is no combinational path from frame_ready or in_valid.
  always_comb begin
    in_ready    = !rst && !full_q[wr_bank_q];
    frame_valid = full_q[rd_bank_q];
    accept      = in_valid && in_ready;
    frame_rel   = frame_valid && frame_ready;
    wr_slot     = (BITREV != 0) ? {wr_cnt_q[0], wr_cnt_q[1], wr_cnt_q[2]} : wr_cnt_q;
  end

  // The read bank is never written while full, so frame_data is stable
  // straight from the bank registers while the frame waits.
  always_comb begin
    frame_data = '0;
    for (int s = 0; s < 8; s++) begin
      frame_data[s*WIDTH +: WIDTH] = bank_q[rd_bank_q][s];
    end
  end

  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;

    // Release and completion always target different banks: a release needs
    // the read bank full, an accept needs the write bank not full.
    if (frame_rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    if (accept) begin
      bank_d[wr_bank_q][wr_slot] = in_data;
      wr_cnt_d                   = wr_cnt_q + 3'd1;
      if (wr_cnt_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < 8; s++) begin
          bank_q[b][s] <= '0;
        end
      end
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= 3'd0;
      rd_bank_q <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Bench for fft_input_buffer: a bit-reversed and a natural-order instance share
// the same stimulus and are checked against a frame-queue reference model.
module tb_fft_input_buffer;

  logic         clk;
  logic         rst;
  logic [15:0]  in_data;
  logic         in_valid;
  logic         frame_ready;
  logic         in_ready_r, in_ready_n;
  logic         frame_valid_r, frame_valid_n;
  logic [127:0] frame_data_r, frame_data_n;

  int errors = 0;
  int checks = 0;

  // Reference model: completed frames in arrival order (natural sample order),
  // plus the partially assembled frame.
  logic [127:0] fq[$];
  logic [127:0] part;
  int           pcnt;

  fft_input_buffer #(.WIDTH(16), .BITREV(1)) u_dut_rev (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready_r),
    .frame_data  (frame_data_r),
    .frame_valid (frame_valid_r),
    .frame_ready (frame_ready)
  );

  fft_input_buffer #(.WIDTH(16), .BITREV(0)) u_dut_nat (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready_n),
    .frame_data  (frame_data_n),
    .frame_valid (frame_valid_n),
    .frame_ready (frame_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] map_frame(input logic [127:0] nat, input bit rev);
    logic [127:0] r;
    int slot;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      slot = rev ? ((k % 2) * 4 + (k & 2) + (k / 4)) : k;
      r[slot*16 +: 16] = nat[k*16 +: 16];
    end
    return r;
  endfunction

  // The buffer can hold two complete frames; input stalls only then.
  function automatic bit exp_ready();
    return !rst && (fq.size() < 2);
  endfunction

  function automatic bit exp_valid();
    return fq.size() > 0;
  endfunction

  function automatic logic [127:0] exp_data(input bit rev);
    return map_frame(fq[0], rev);
  endfunction

  // Advance the model with the currently driven inputs, then clock the DUTs.
  task automatic tick();
    bit acc, rel;
    if (rst) begin
      fq.delete();
      part = '0;
      pcnt = 0;
    end else begin
      acc = in_valid && (fq.size() < 2);
      rel = frame_ready && (fq.size() > 0);
      if (rel) void'(fq.pop_front());
      if (acc) begin
        part[pcnt*16 +: 16] = in_data;
        pcnt++;
        if (pcnt == 8) begin
          fq.push_back(part);
          part = '0;
          pcnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    frame_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hdead;
    frame_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready_r !== 1'b0 || in_ready_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready_low: got %b/%b want 0", in_ready_r, in_ready_n);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready_r !== 1'b1 || in_ready_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_rel: got %b/%b want 1", in_ready_r, in_ready_n);
    end
    checks++;
    if (frame_valid_r !== 1'b0 || frame_valid_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b/%b want 0", frame_valid_r, frame_valid_n);
    end
    checks++;
    if (frame_data_r !== 128'd0 || frame_data_n !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 0", frame_data_r, frame_data_n);
    end
  endtask

  task automatic test_order();
    logic [127:0] want_rev, want_nat;
    want_rev = {16'h0080, 16'h0040, 16'h0060, 16'h0020,
                16'h0070, 16'h0030, 16'h0050, 16'h0010};
    want_nat = {16'h0080, 16'h0070, 16'h0060, 16'h0050,
                16'h0040, 16'h0030, 16'h0020, 16'h0010};
    apply_reset();
    frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data = 16'(16 * (k + 1));
      checks++;
      if (in_ready_r !== 1'b1 || frame_valid_r !== 1'b0) begin
        errors++;
        $display("FAIL order_fill k=%0d: ready/valid %b/%b want 1/0", k, in_ready_r,
                 frame_valid_r);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (frame_valid_r !== 1'b1 || frame_valid_n !== 1'b1) begin
      errors++;
      $display("FAIL order_latency: valid %b/%b want 1", frame_valid_r, frame_valid_n);
    end
    checks++;
    if (frame_data_r !== want_rev) begin
      errors++;
      $display("FAIL order_bitrev: got %h want %h", frame_data_r, want_rev);
    end
    checks++;
    if (frame_data_n !== want_nat) begin
      errors++;
      $display("FAIL order_natural: got %h want %h", frame_data_n, want_nat);
    end
    tick();
    checks++;
    if (frame_valid_r !== 1'b0 || frame_valid_n !== 1'b0) begin
      errors++;
      $display("FAIL order_one_cycle: valid %b/%b want 0", frame_valid_r, frame_valid_n);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int held_cycles;
    bit have_held;
    logic [127:0] held, want;
    apply_reset();
    frame_ready = 1'b0;
    in_valid = 1'b1;
    idx = 1;
    held_cycles = 0;
    have_held = 0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      in_data = 16'(idx);
      checks++;
      if (in_ready_r !== exp_ready() || in_ready_n !== exp_ready()) begin
        errors++;
        $display("FAIL bp_in_ready c=%0d: got %b/%b want %b", c, in_ready_r, in_ready_n,
                 exp_ready());
      end
      checks++;
      if (frame_valid_r !== exp_valid()) begin
        errors++;
        $display("FAIL bp_valid c=%0d: got %b want %b", c, frame_valid_r, exp_valid());
      end
      if (frame_valid_r === 1'b1) begin
        if (!have_held) begin
          held = frame_data_r;
          have_held = 1;
        end
        held_cycles++;
        checks++;
        if (frame_data_r !== held || frame_data_r !== exp_data(1)) begin
          errors++;
          $display("FAIL bp_stable c=%0d: got %h want %h", c, frame_data_r, exp_data(1));
        end
      end
      if (exp_ready()) idx++;
      tick();
    end
    checks++;
    if (idx != 17 || in_ready_r !== 1'b0 || held_cycles < 10) begin
      errors++;
      $display("FAIL bp_holdoff: next=%0d ready=%b held=%0d want 17/0/>=10", idx, in_ready_r,
               held_cycles);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    want = '0;
    for (int k = 0; k < 8; k++) want[k*16 +: 16] = 16'(9 + k);
    checks++;
    if (frame_valid_r !== 1'b1 || frame_data_r !== map_frame(want, 1)
        || frame_data_n !== want) begin
      errors++;
      $display("FAIL bp_second_frame: got %h/%h want %h", frame_data_r, frame_data_n, want);
    end
    checks++;
    if (in_ready_r !== 1'b1 || in_ready_n !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after_release: got %b/%b want 1", in_ready_r, in_ready_n);
    end
    // Sample 17 is offered now; frame 17..24 proves it was taken.
    in_data = 16'd17;
    tick();
    frame_ready = 1'b1;
    for (int k = 18; k <= 24; k++) begin
      in_data = 16'(k);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) want[k*16 +: 16] = 16'(17 + k);
    checks++;
    if (frame_valid_r !== 1'b1 || frame_data_r !== map_frame(want, 1)
        || frame_data_n !== want) begin
      errors++;
      $display("FAIL bp_third_frame: got %h/%h want %h", frame_data_r, frame_data_n, want);
    end
    tick();
  endtask

  task automatic test_streaming();
    int pulses;
    int last_c;
    apply_reset();
    frame_ready = 1'b1;
    pulses = 0;
    last_c = -1;
    for (int c = 0; c < 66; c++) begin
      in_valid = (c < 64);
      in_data = 16'($urandom);
      if (c < 64) begin
        checks++;
        if (in_ready_r !== 1'b1 || in_ready_n !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready c=%0d: got %b/%b want 1", c, in_ready_r, in_ready_n);
        end
      end
      checks++;
      if (frame_valid_r !== exp_valid() || frame_valid_n !== exp_valid()) begin
        errors++;
        $display("FAIL stream_valid c=%0d: got %b/%b want %b", c, frame_valid_r,
                 frame_valid_n, exp_valid());
      end
      if (frame_valid_r === 1'b1 && exp_valid()) begin
        pulses++;
        checks++;
        if (frame_data_r !== exp_data(1) || frame_data_n !== exp_data(0)) begin
          errors++;
          $display("FAIL stream_data c=%0d: got %h/%h want %h/%h", c, frame_data_r,
                   frame_data_n, exp_data(1), exp_data(0));
        end
        checks++;
        if (last_c >= 0 && c - last_c != 8) begin
          errors++;
          $display("FAIL stream_spacing c=%0d: got %0d want 8", c, c - last_c);
        end
        last_c = c;
      end
      tick();
    end
    checks++;
    if (pulses != 8) begin
      errors++;
      $display("FAIL stream_pulses: got %0d want 8", pulses);
    end
  endtask

  task automatic test_gaps();
    logic [127:0] nat;
    int n;
    apply_reset();
    frame_ready = 1'b0;
    nat = '0;
    n = 0;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c % 2 == 0);
      in_data = 16'($urandom);
      if (in_valid) begin
        nat[n*16 +: 16] = in_data;
        n++;
      end
      if (c == 14) begin
        checks++;
        if (frame_valid_r !== 1'b0) begin
          errors++;
          $display("FAIL gaps_early_valid: got %b want 0", frame_valid_r);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (frame_valid_r !== 1'b1 || frame_data_r !== map_frame(nat, 1)
        || frame_data_n !== nat) begin
      errors++;
      $display("FAIL gaps_frame: got %b %h/%h want %h", frame_valid_r, frame_data_r,
               frame_data_n, nat);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] nat;
    apply_reset();
    frame_ready = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0: partial frame of 5; pass 1: both banks full and stalled
      in_valid = 1'b1;
      for (int k = 0; k < (pass == 0 ? 5 : 16); k++) begin
        in_data = 16'($urandom);
        tick();
      end
      if (pass == 1) begin
        checks++;
        if (frame_valid_r !== 1'b1 || in_ready_r !== 1'b0) begin
          errors++;
          $display("FAIL rmid_stalled: valid/ready %b/%b want 1/0", frame_valid_r, in_ready_r);
        end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (frame_valid_r !== 1'b0 || frame_valid_n !== 1'b0 || frame_data_r !== 128'd0
          || frame_data_n !== 128'd0) begin
        errors++;
        $display("FAIL rmid_clear pass=%0d: valid %b data %h want 0", pass, frame_valid_r,
                 frame_data_r);
      end
      nat = '0;
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        in_data = 16'($urandom);
        nat[k*16 +: 16] = in_data;
        tick();
      end
      in_valid = 1'b0;
      checks++;
      if (frame_valid_r !== 1'b1 || frame_data_r !== map_frame(nat, 1)
          || frame_data_n !== nat || frame_data_r !== exp_data(1)) begin
        errors++;
        $display("FAIL rmid_frame pass=%0d: got %b %h want %h", pass, frame_valid_r,
                 frame_data_r, map_frame(nat, 1));
      end
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    frame_ready = 1'b0;
    part = '0;
    pcnt = 0;
    test_reset();
    test_order();
    test_backpressure();
    test_streaming();
    test_gaps();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
